// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'd4;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between fetch and imem.
interface fetch_stage_if;
    import mips_fetch_pkg::*;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight at a
// time, and presents each fetched instruction (with PC+4) to IF/ID, or a NOP
// bubble when nothing is available.
module fetch_stage
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    fetch_stage_if.master        mem,
    output logic [31:0]          pc_out,
    output logic [31:0]          inst_out,
    output logic                 inst_valid
);

    fetch_state_t state_r;
    logic [31:0]  pc_r;
    logic [31:0]  pc_q_r;
    logic [31:0]  inst_q_r;
    logic         inst_valid_r;
    logic         kill_r;
    logic         req_s;

    // Request is raised in S_REQ, or in S_HOLD when the held instruction is
    // being consumed; a redirect suppresses it for that cycle.
    always_comb begin
        req_s = 1'b0;
        case (state_r)
            S_REQ:   req_s = !redirect_valid;
            S_HOLD:  req_s = !freeze && !redirect_valid;
            S_WAIT:  req_s = 1'b0;
            default: req_s = 1'b0;
        endcase
    end

    assign mem.imem_req  = req_s;
    assign mem.imem_addr = pc_r;
    assign pc_out        = pc_q_r;
    assign inst_out      = inst_q_r;
    assign inst_valid    = inst_valid_r;

    // Fetch FSM with PC, kill flag and the registered IF/ID-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_REQ;
            pc_r         <= RESET_PC;
            pc_q_r       <= 32'h0000_0000;
            inst_q_r     <= NOP_INST;
            inst_valid_r <= 1'b0;
            kill_r       <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect wins in every state; any held or arriving instruction
            // is from the wrong path and is discarded.
            pc_r         <= align_word(redirect_pc);
            pc_q_r       <= 32'h0000_0000;
            inst_q_r     <= NOP_INST;
            inst_valid_r <= 1'b0;
            case (state_r)
                S_WAIT: begin
                    if (mem.imem_rvalid) begin
                        state_r <= S_REQ;
                        kill_r  <= 1'b0;
                    end else begin
                        // The in-flight response still has to be absorbed.
                        kill_r  <= 1'b1;
                    end
                end
                default: state_r <= S_REQ;
            endcase
        end else begin
            case (state_r)
                S_REQ: begin
                    if (mem.imem_ready) begin
                        state_r <= S_WAIT;
                    end else begin
                        state_r <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (mem.imem_rvalid && kill_r) begin
                        kill_r  <= 1'b0;
                        state_r <= S_REQ;
                    end else if (mem.imem_rvalid) begin
                        inst_q_r     <= mem.imem_rdata;
                        pc_q_r       <= pc_r + PC_INC;
                        pc_r         <= pc_r + PC_INC;
                        inst_valid_r <= 1'b1;
                        state_r      <= S_HOLD;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (!freeze) begin
                        // Consumed downstream at this edge; next fetch overlaps.
                        inst_valid_r <= 1'b0;
                        pc_q_r       <= 32'h0000_0000;
                        inst_q_r     <= NOP_INST;
                        if (mem.imem_ready) begin
                            state_r <= S_WAIT;
                        end else begin
                            state_r <= S_REQ;
                        end
                    end else begin
                        state_r <= S_HOLD;
                    end
                end
                default: state_r <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: two instances, one at the default reset PC
// and one at 32'hFFFF_FFFC for the wrap-around case.
module tb_fetch_stage;
    import mips_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] pc_out, inst_out;
    logic        inst_valid;

    logic        rst1 = 1'b1;
    logic [31:0] pc_out1, inst_out1;
    logic        inst_valid1;

    int tests = 0;
    int fails = 0;
    int accepts0 = 0;

    fetch_stage_if bus0 ();
    fetch_stage_if bus1 ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem(bus0), .pc_out(pc_out), .inst_out(inst_out), .inst_valid(inst_valid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst(rst1), .freeze(1'b0),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .mem(bus1), .pc_out(pc_out1), .inst_out(inst_out1), .inst_valid(inst_valid1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus0.imem_req && bus0.imem_ready) accepts0 <= accepts0 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus0.imem_ready = 1'b0; bus0.imem_rvalid = 1'b0; bus0.imem_rdata = 32'h0;
        bus1.imem_ready = 1'b0; bus1.imem_rvalid = 1'b0; bus1.imem_rdata = 32'h0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
        tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL reset_pc_out: got %h expected 0", pc_out); end
        tests++; if (inst_out !== 32'h0) begin fails++; $display("FAIL reset_inst_out: got %h expected 0", inst_out); end
        tests++; if (bus0.imem_req !== 1'b1) begin fails++; $display("FAIL reset_req: got %b expected 1", bus0.imem_req); end
        tests++; if (bus0.imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h expected 0", bus0.imem_addr); end
    endtask

    task automatic test_zero_wait();
        bus0.imem_ready = 1'b1;
        tick();
        bus0.imem_ready = 1'b0; bus0.imem_rvalid = 1'b1; bus0.imem_rdata = 32'h2008_0005;
        #1;
        tests++; if (bus0.imem_req !== 1'b0) begin fails++; $display("FAIL zw_req_in_wait: got %b expected 0", bus0.imem_req); end
        tick();
        bus0.imem_rvalid = 1'b0;
        #1;
        tests++; if (inst_out !== 32'h2008_0005) begin fails++; $display("FAIL zw_inst: got %h expected 20080005", inst_out); end
        tests++; if (pc_out !== 32'h4) begin fails++; $display("FAIL zw_pc_out: got %h expected 4", pc_out); end
        tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL zw_valid: got %b expected 1", inst_valid); end
        tests++; if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h4) begin fails++; $display("FAIL zw_next_req: got req=%b addr=%h expected req=1 addr=4", bus0.imem_req, bus0.imem_addr); end
        tick();  // consumed, memory not ready -> S_REQ
        tests++; if (inst_valid !== 1'b0 || inst_out !== 32'h0 || pc_out !== 32'h0) begin fails++; $display("FAIL zw_bubble: got v=%b inst=%h pc=%h expected 0/0/0", inst_valid, inst_out, pc_out); end
    endtask

    task automatic test_wait_states();
        int a;
        a = accepts0;
        for (int i = 0; i < 3; i++) begin
            tests++; if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h4) begin fails++; $display("FAIL ws_req_stable[%0d]: got req=%b addr=%h expected req=1 addr=4", i, bus0.imem_req, bus0.imem_addr); end
            tick();
        end
        bus0.imem_ready = 1'b1;
        tick();
        bus0.imem_ready = 1'b1;  // held high to expose a duplicate request
        #1;
        tests++; if (bus0.imem_req !== 1'b0) begin fails++; $display("FAIL ws_no_dup_req: got %b expected 0", bus0.imem_req); end
        tick();
        bus0.imem_ready = 1'b0; bus0.imem_rvalid = 1'b1; bus0.imem_rdata = 32'h8C09_0004;
        tick();
        bus0.imem_rvalid = 1'b0;
        #1;
        tests++; if (inst_valid !== 1'b1 || inst_out !== 32'h8C09_0004 || pc_out !== 32'h8) begin fails++; $display("FAIL ws_data: got v=%b inst=%h pc=%h expected 1/8c090004/8", inst_valid, inst_out, pc_out); end
        tests++; if (accepts0 - a !== 1) begin fails++; $display("FAIL ws_accept_count: got %0d expected 1", accepts0 - a); end
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        #1;
        tests++; if (bus0.imem_req !== 1'b0) begin fails++; $display("FAIL fz_req: got %b expected 0", bus0.imem_req); end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (inst_out !== 32'h8C09_0004 || pc_out !== 32'h8 || inst_valid !== 1'b1 || bus0.imem_req !== 1'b0) begin fails++; $display("FAIL fz_hold[%0d]: got inst=%h pc=%h v=%b req=%b expected 8c090004/8/1/0", i, inst_out, pc_out, inst_valid, bus0.imem_req); end
        end
        freeze = 1'b0;
        #1;
        tests++; if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h8) begin fails++; $display("FAIL fz_release_req: got req=%b addr=%h expected req=1 addr=8", bus0.imem_req, bus0.imem_addr); end
        bus0.imem_ready = 1'b1;
        tick();
        bus0.imem_ready = 1'b0;
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL fz_consumed: got %b expected 0", inst_valid); end
    endtask

    task automatic test_redirect_wait();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        #1;
        tests++; if (bus0.imem_req !== 1'b0) begin fails++; $display("FAIL rw_req_while_kill: got %b expected 0", bus0.imem_req); end
        tick();
        bus0.imem_rvalid = 1'b1; bus0.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus0.imem_rvalid = 1'b0;
        #1;
        tests++; if (inst_valid !== 1'b0 || inst_out !== 32'h0) begin fails++; $display("FAIL rw_dropped: got v=%b inst=%h expected 0/0", inst_valid, inst_out); end
        tests++; if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h0000_0100) begin fails++; $display("FAIL rw_target: got req=%b addr=%h expected req=1 addr=100", bus0.imem_req, bus0.imem_addr); end
    endtask

    task automatic test_redirect_rvalid();
        bus0.imem_ready = 1'b1;
        tick();
        bus0.imem_ready = 1'b0; bus0.imem_rvalid = 1'b1; bus0.imem_rdata = 32'h1111_2222;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        bus0.imem_rvalid = 1'b0; redirect_valid = 1'b0;
        #1;
        tests++; if (inst_valid !== 1'b0 || inst_out !== 32'h0 || pc_out !== 32'h0) begin fails++; $display("FAIL rr_dropped: got v=%b inst=%h pc=%h expected 0/0/0", inst_valid, inst_out, pc_out); end
        tests++; if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h0000_0200) begin fails++; $display("FAIL rr_target: got req=%b addr=%h expected req=1 addr=200", bus0.imem_req, bus0.imem_addr); end
    endtask

    task automatic test_redirect_freeze();
        bus0.imem_ready = 1'b1;
        tick();
        bus0.imem_ready = 1'b0; bus0.imem_rvalid = 1'b1; bus0.imem_rdata = 32'h2409_0007;
        tick();
        bus0.imem_rvalid = 1'b0;
        #1;
        tests++; if (inst_valid !== 1'b1 || pc_out !== 32'h0000_0204) begin fails++; $display("FAIL rf_loaded: got v=%b pc=%h expected 1/204", inst_valid, pc_out); end
        freeze = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        #1;
        tests++; if (bus0.imem_req !== 1'b0) begin fails++; $display("FAIL rf_req: got %b expected 0", bus0.imem_req); end
        tick();
        freeze = 1'b0; redirect_valid = 1'b0;
        #1;
        tests++; if (inst_valid !== 1'b0 || inst_out !== 32'h0 || pc_out !== 32'h0) begin fails++; $display("FAIL rf_dropped: got v=%b inst=%h pc=%h expected 0/0/0", inst_valid, inst_out, pc_out); end
        tests++; if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h0000_0300) begin fails++; $display("FAIL rf_target: got req=%b addr=%h expected req=1 addr=300", bus0.imem_req, bus0.imem_addr); end
    endtask

    task automatic test_wrap_and_reset();
        rst1 = 1'b0;
        #1;
        tests++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wr_start: got req=%b addr=%h expected req=1 addr=fffffffc", bus1.imem_req, bus1.imem_addr); end
        bus1.imem_ready = 1'b1;
        tick();
        bus1.imem_ready = 1'b0; bus1.imem_rvalid = 1'b1; bus1.imem_rdata = 32'h0340_0008;
        tick();
        bus1.imem_rvalid = 1'b0;
        #1;
        tests++; if (inst_valid1 !== 1'b1 || pc_out1 !== 32'h0 || inst_out1 !== 32'h0340_0008) begin fails++; $display("FAIL wr_fetch: got v=%b pc=%h inst=%h expected 1/0/03400008", inst_valid1, pc_out1, inst_out1); end
        tests++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 32'h0) begin fails++; $display("FAIL wr_next_addr: got req=%b addr=%h expected req=1 addr=0", bus1.imem_req, bus1.imem_addr); end
        bus1.imem_ready = 1'b1;
        tick();  // consumed, next request accepted -> S_WAIT
        bus1.imem_ready = 1'b0; rst1 = 1'b1;
        tick();
        rst1 = 1'b0; bus1.imem_rvalid = 1'b1; bus1.imem_rdata = 32'hBAD0_BAD0;
        tick();
        bus1.imem_rvalid = 1'b0;
        #1;
        tests++; if (inst_valid1 !== 1'b0 || inst_out1 !== 32'h0 || pc_out1 !== 32'h0) begin fails++; $display("FAIL wr_late_rvalid: got v=%b inst=%h pc=%h expected 0/0/0", inst_valid1, inst_out1, pc_out1); end
        tests++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wr_after_reset: got req=%b addr=%h expected req=1 addr=fffffffc", bus1.imem_req, bus1.imem_addr); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_freeze();
        test_redirect_wait();
        test_redirect_rvalid();
        test_redirect_freeze();
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It sits directly upstream of the IF/ID pipeline register. It owns the program counter and issues one instruction-memory request at a time over a ready/valid handshake. It presents each fetched instruction with its PC+4, and emits a NOP bubble (inst = 0, pc = 0) whenever no instruction is available. It honours freeze from the hazard unit and redirects from branch/jump resolution.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- freeze  in  1  hazard-unit stall; downstream register is not capturing this cycle
- redirect_valid  in  1  one-cycle pulse: taken branch/jump resolved
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0)
- imem_req  out  1  request valid
- imem_addr  out  32  word-aligned fetch address (= pc)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  instruction word
- pc_out  out  32  PC+4 of held instruction, 0 when bubble
- inst_out  out  32  held instruction, 0 (NOP) when bubble
- inst_valid  out  1  pc_out/inst_out carry a real instruction

## Operation
- State machine with three states:
  - S_REQ: imem_req = !redirect_valid. Request accepted when imem_req & imem_ready, then go to S_WAIT.
  - S_WAIT: waiting for imem_rvalid. On response, go to S_HOLD, or to S_REQ if the response is dropped (see below).
  - S_HOLD: instruction presented downstream.
- Accepted response (S_WAIT, imem_rvalid, kill = 0, no redirect):
  - inst_q <= imem_rdata, pc_q <= pc+4, inst_valid <= 1, pc <= pc+4.
  - Go to S_HOLD.
- S_HOLD with freeze = 1: hold everything and keep imem_req = 0.
- S_HOLD with freeze = 0: the instruction is consumed at this edge, and inst_valid <= 0.
  - imem_req = 1 in the same cycle (addr = pc).
  - If imem_ready, go to S_WAIT; else go to S_REQ.
- In S_REQ and S_WAIT, freeze has no effect; a fetch completes and waits in S_HOLD.
- redirect_valid has the highest priority in every state:
  - pc <= {redirect_pc[31:2], 2'b00}; inst_valid <= 0; pc_q, inst_q <= 0.
  - From S_HOLD or S_REQ, go to S_REQ (no request is issued in the redirect cycle).
  - From S_WAIT without imem_rvalid: kill <= 1 and stay in S_WAIT.
  - From S_WAIT with imem_rvalid in the same cycle: drop the data and go to S_REQ.
- S_WAIT with kill = 1 and imem_rvalid: drop the data, kill <= 0, go to S_REQ.
- A redirect while kill = 1 only updates pc.
- imem_rvalid outside S_WAIT is ignored.
- PC arithmetic is 32-bit unsigned and wraps modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
- At most one request is outstanding at any time.

## Timing
- Reset values: pc = RESET_PC, state = S_REQ, kill = 0, inst_valid = 0, pc_out = 0, inst_out = 0, imem_req = 1 in the first cycle after reset.
- Reset mid-transaction abandons the transaction; the late response is ignored since state ≠ S_WAIT.
- Memory with zero wait states and imem_rvalid one cycle after acceptance:
  - request accepted at edge N, data at edge N+1, inst_valid high from N+1.
  - steady-state throughput is one instruction per 2 cycles, with S_HOLD overlapping the next request.
- Outputs pc_out, inst_out and inst_valid are registered. imem_req and imem_addr are combinational from state, pc, freeze and redirect_valid.
- Redirect to the first request of the target: 1 cycle (redirect cycle, then S_REQ).

## Structure
- Shared package mips_fetch_pkg:
  - state enum fetch_state_t {S_REQ, S_WAIT, S_HOLD}
  - NOP_INST = 32'h0000_0000
  - PC_INC = 32'd4
- Single module; no sub-module needed. The pc register with next-pc mux may be split out as fetch_pc_reg if reused by the branch predictor.

## Test plan
- Reset, then zero-wait memory returning 32'h2008_0005 at 0x0 → imem_addr 0x0; inst_out = 32'h2008_0005, pc_out = 4, inst_valid = 1; next request at addr 0x4.
- Memory holds imem_ready low 3 cycles, then imem_rvalid 2 cycles after acceptance → imem_req stays high and imem_addr stable throughout; one instruction is delivered and no duplicate request is issued.
- freeze = 1 for 4 cycles while in S_HOLD → inst_out and pc_out unchanged and imem_req = 0; request for the next pc issued in the first cycle freeze = 0.
- redirect_valid with redirect_pc = 0x0000_0103 while in S_WAIT, data arriving 2 cycles later → data dropped and inst_valid stays 0; next imem_addr = 0x0000_0100.
- redirect_valid coincident with imem_rvalid, and separately coincident with freeze in S_HOLD → the instruction is discarded in both cases; outputs are 0 next cycle and the fetch restarts at the target.
- RESET_PC = 32'hFFFF_FFFC, one fetch → pc_out = 0, next imem_addr = 0; rst asserted mid-S_WAIT then late imem_rvalid → ignored, outputs remain 0.
